// File: rtl/ascii_num_parser.sv
// ascii_num_parser: assembles a line of ASCII decimal digits into an unsigned
// binary value. The value is published on a line terminator (CR or LF).
// Lines holding non-digit characters, or more than MAX_DIGITS digits, end in
// an error pulse instead, and the last good value is kept.
module ascii_num_parser #(
  parameter int MAX_DIGITS = 5,
  parameter int WIDTH      = 17
) (
  input  logic             iCLK,
  input  logic             iRST_n,
  input  logic [7:0]       iASC,
  input  logic [3:0]       iDec,
  input  logic             iValid,
  input  logic             iClear,
  output logic [WIDTH-1:0] oValue,
  output logic             oValid,
  output logic             oErr,
  output logic [3:0]       oDigits,
  output logic             oBusy
);

  typedef enum logic [1:0] {IDLE, ACCUM, DISCARD} state_e;

  localparam logic [3:0] MAX_D = 4'(MAX_DIGITS);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] value_q, value_d;
  logic [3:0]       digits_q, digits_d;
  logic             valid_q, valid_d;
  logic             err_q, err_d;

  logic is_digit;
  logic is_term;

  // Classify the byte from the raw ASCII code. iDec supplies only the digit value.
  assign is_digit = (iASC >= 8'h30) && (iASC <= 8'h39);
  assign is_term  = (iASC == 8'h0D) || (iASC == 8'h0A);

  // acc*10 + dec, using shifts in a widened word. The digit limit keeps the
  // result inside WIDTH bits, so the truncation at the end never drops bits.
  function automatic logic [WIDTH-1:0] mac10(input logic [WIDTH-1:0] acc,
                                             input logic [3:0]       dec);
    logic [WIDTH+3:0] ext;
    ext = {4'b0000, acc};
    ext = (ext << 3) + (ext << 1) + {{WIDTH{1'b0}}, dec};
    return ext[WIDTH-1:0];
  endfunction

  // State register
  always_ff @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // Next-state logic. iClear overrides a byte strobe in the same cycle.
  always_comb begin
    state_d = state_q;
    if (iClear) begin
      state_d = IDLE;
    end else if (iValid) begin
      case (state_q)
        IDLE: begin
          if (is_digit)     state_d = ACCUM;
          else if (!is_term) state_d = DISCARD;
        end
        ACCUM: begin
          if (is_term)                             state_d = IDLE;
          else if (!is_digit || digits_q == MAX_D) state_d = DISCARD;
        end
        DISCARD: begin
          if (is_term) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Datapath and pulse next values. Both pulses default low, so each lasts one cycle.
  always_comb begin
    acc_d    = acc_q;
    digits_d = digits_q;
    value_d  = value_q;
    valid_d  = 1'b0;
    err_d    = 1'b0;
    if (iClear) begin
      acc_d    = '0;
      digits_d = 4'd0;
    end else if (iValid) begin
      case (state_q)
        IDLE: begin
          if (is_digit) begin
            acc_d    = {{(WIDTH-4){1'b0}}, iDec};
            digits_d = 4'd1;
          end
        end
        ACCUM: begin
          if (is_term) begin
            value_d  = acc_q;
            valid_d  = 1'b1;
            acc_d    = '0;
            digits_d = 4'd0;
          end else if (is_digit && digits_q < MAX_D) begin
            acc_d    = mac10(acc_q, iDec);
            digits_d = digits_q + 4'd1;
          end
        end
        DISCARD: begin
          if (is_term) begin
            err_d    = 1'b1;
            acc_d    = '0;
            digits_d = 4'd0;
          end
        end
        default: begin
          acc_d    = '0;
          digits_d = 4'd0;
        end
      endcase
    end
  end

  // Accumulator, published value and the output pulse registers
  always_ff @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n) begin
      acc_q    <= '0;
      digits_q <= 4'd0;
      value_q  <= '0;
      valid_q  <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      acc_q    <= acc_d;
      digits_q <= digits_d;
      value_q  <= value_d;
      valid_q  <= valid_d;
      err_q    <= err_d;
    end
  end

  assign oValue  = value_q;
  assign oValid  = valid_q;
  assign oErr    = err_q;
  assign oDigits = digits_q;
  assign oBusy   = (state_q != IDLE);

endmodule

// File: tb/tb_ascii_num_parser.sv
// Testbench for ascii_num_parser: a table of byte steps with expected results,
// a scoreboard for the output pulses, and hand-written reset sequences.
module tb_ascii_num_parser;
  localparam int WIDTH = 17;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [7:0]       asc;
  logic [3:0]       dec;
  logic             valid;
  logic             clear;
  logic [WIDTH-1:0] value;
  logic             ovalid;
  logic             oerr;
  logic [3:0]       odigits;
  logic             obusy;

  always #5 clk = ~clk;

  ascii_num_parser #(.MAX_DIGITS(5), .WIDTH(WIDTH)) dut (
    .iCLK   (clk),
    .iRST_n (rst_n),
    .iASC   (asc),
    .iDec   (dec),
    .iValid (valid),
    .iClear (clear),
    .oValue (value),
    .oValid (ovalid),
    .oErr   (oerr),
    .oDigits(odigits),
    .oBusy  (obusy)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // pulse code: 0 = none, 1 = oValid, 2 = oErr (matches {oErr, oValid})
  typedef struct {
    logic [7:0]  asc;
    logic        clr;
    logic        gap;
    logic [3:0]  exp_dig;
    logic        exp_busy;
    logic [1:0]  exp_pulse;
    logic [31:0] exp_val;
  } vec_t;

  typedef struct {
    logic [1:0]  kind;
    logic [31:0] val;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  exp_t sb_e;

  function automatic void add(input logic [7:0] a, input logic c, input logic g,
                              input logic [3:0] d, input logic b, input logic [1:0] p,
                              input logic [31:0] v);
    vec_t r;
    r.asc = a; r.clr = c; r.gap = g; r.exp_dig = d; r.exp_busy = b;
    r.exp_pulse = p; r.exp_val = v;
    vecs.push_back(r);
  endfunction

  // Drive one byte strobe, check state after the clock edge; gap=1 idles 9 cycles.
  task automatic step(input vec_t v);
    exp_t e;
    @(negedge clk);
    valid = 1'b1;
    asc   = v.asc;
    dec   = (v.asc >= 8'h30 && v.asc <= 8'h39) ? 4'(v.asc - 8'h30) : 4'd0;
    clear = v.clr;
    if (v.exp_pulse != 2'd0) begin
      e.kind = v.exp_pulse;
      e.val  = v.exp_val;
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
    check("digits", 32'(odigits), 32'(v.exp_dig));
    check("busy", 32'(obusy), 32'(v.exp_busy));
    check("value", 32'(value), v.exp_val);
    check("pulse", 32'({oerr, ovalid}), 32'(v.exp_pulse));
    if (v.gap) begin
      @(negedge clk);
      valid = 1'b0;
      clear = 1'b0;
      repeat (8) @(negedge clk);
    end
  endtask

  // Scoreboard monitor: every pulse must match the next queued expectation.
  always @(posedge clk) begin
    #1;
    if (ovalid && oerr) begin
      checks++;
      errors++;
      $display("FAIL both_pulses: oValid and oErr high together at %0t", $time);
    end else if (ovalid || oerr) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL stray_pulse: got valid=%0b err=%0b value=%0d expected no pulse at %0t",
                 ovalid, oerr, value, $time);
      end else begin
        sb_e = sb.pop_front();
        check("sb_kind", 32'({oerr, ovalid}), 32'(sb_e.kind));
        check("sb_value", 32'(value), sb_e.val);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; valid = 1'b0; clear = 1'b0; asc = 8'h00; dec = 4'd0;
    repeat (3) @(negedge clk);
    #1;
    check("rst_value", 32'(value), 32'd0);
    check("rst_valid", 32'(ovalid), 32'd0);
    check("rst_err", 32'(oerr), 32'd0);
    check("rst_digits", 32'(odigits), 32'd0);
    check("rst_busy", 32'(obusy), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // "123" CR, one byte per 10 cycles
    add(8'h31, 0, 1, 1, 1, 0, 0);
    add(8'h32, 0, 1, 2, 1, 0, 0);
    add(8'h33, 0, 1, 3, 1, 0, 0);
    add(8'h0D, 0, 1, 0, 0, 1, 123);
    // "45" CR LF: the LF is absorbed
    add(8'h34, 0, 1, 1, 1, 0, 123);
    add(8'h35, 0, 1, 2, 1, 0, 123);
    add(8'h0D, 0, 1, 0, 0, 1, 45);
    add(8'h0A, 0, 1, 0, 0, 0, 45);
    // "123456" LF overflows, then "99999" LF
    add(8'h31, 0, 1, 1, 1, 0, 45);
    add(8'h32, 0, 1, 2, 1, 0, 45);
    add(8'h33, 0, 1, 3, 1, 0, 45);
    add(8'h34, 0, 1, 4, 1, 0, 45);
    add(8'h35, 0, 1, 5, 1, 0, 45);
    add(8'h36, 0, 1, 5, 1, 0, 45);
    add(8'h0A, 0, 1, 0, 0, 2, 45);
    add(8'h39, 0, 1, 1, 1, 0, 45);
    add(8'h39, 0, 1, 2, 1, 0, 45);
    add(8'h39, 0, 1, 3, 1, 0, 45);
    add(8'h39, 0, 1, 4, 1, 0, 45);
    add(8'h39, 0, 1, 5, 1, 0, 45);
    add(8'h0A, 0, 1, 0, 0, 1, 99999);
    // "12a4" LF is malformed, then "7" CR
    add(8'h31, 0, 1, 1, 1, 0, 99999);
    add(8'h32, 0, 1, 2, 1, 0, 99999);
    add(8'h61, 0, 1, 2, 1, 0, 99999);
    add(8'h34, 0, 1, 2, 1, 0, 99999);
    add(8'h0A, 0, 1, 0, 0, 2, 99999);
    add(8'h37, 0, 1, 1, 1, 0, 99999);
    add(8'h0D, 0, 1, 0, 0, 1, 7);
    // back-to-back "3" "1" CR
    add(8'h33, 0, 0, 1, 1, 0, 7);
    add(8'h31, 0, 0, 2, 1, 0, 7);
    add(8'h0D, 0, 1, 0, 0, 1, 31);
    // leading zeros "007" CR
    add(8'h30, 0, 1, 1, 1, 0, 31);
    add(8'h30, 0, 1, 2, 1, 0, 31);
    add(8'h37, 0, 1, 3, 1, 0, 31);
    add(8'h0D, 0, 1, 0, 0, 1, 7);
    // non-digit as first byte of a line
    add(8'h78, 0, 1, 0, 1, 0, 7);
    add(8'h0D, 0, 1, 0, 0, 2, 7);
    // iClear with a "5" strobe after "12", then "9" CR
    add(8'h31, 0, 1, 1, 1, 0, 7);
    add(8'h32, 0, 1, 2, 1, 0, 7);
    add(8'h35, 1, 1, 0, 0, 0, 7);
    add(8'h39, 0, 1, 1, 1, 0, 7);
    add(8'h0D, 0, 1, 0, 0, 1, 9);
    // "88" before a mid-line reset
    add(8'h38, 0, 1, 1, 1, 0, 9);
    add(8'h38, 0, 1, 2, 1, 0, 9);

    for (int i = 0; i < vecs.size(); i++) step(vecs[i]);

    // Reset mid-line: partial "88" is dropped and oValue returns to 0
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_value", 32'(value), 32'd0);
    check("midrst_digits", 32'(odigits), 32'd0);
    check("midrst_busy", 32'(obusy), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    vecs.delete();
    add(8'h36, 0, 1, 1, 1, 0, 0);
    add(8'h0D, 0, 1, 0, 0, 1, 6);
    for (int i = 0; i < vecs.size(); i++) step(vecs[i]);

    repeat (5) @(negedge clk);
    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
